// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for an RV32I subset (R/I ALU, lw, sw, beq).
// Sequences IF/ID/EX/MEM/WB and drives the ALU op code and datapath strobes.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic        load_pc,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam int unsigned OP_W = 4;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R = 3'd0,
    C_ALU_I = 3'd1,
    C_LW    = 3'd2,
    C_SW    = 3'd3,
    C_BEQ   = 3'd4
  } cls_t;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_LT  = 4'b0100;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLL = 4'b1001;
  localparam logic [OP_W-1:0] OP_SRA = 4'b1010;

  state_t          cur_state, next_state;
  logic [31:0]     ir;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            dec_legal;
  cls_t            dec_cls;
  logic [OP_W-1:0] dec_op;
  logic            unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};
  assign state     = cur_state;

  // State register and instruction latch (ir only captured in IF)
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IF;
      ir        <= 32'h0;
    end else begin
      cur_state <= next_state;
      if (cur_state == S_IF) ir <= instr;
    end
  end

  // Instruction decode from the latched ir
  always_comb begin
    dec_legal = 1'b0;
    dec_cls   = C_ALU_R;
    dec_op    = OP_ADD;
    case (opcode)
      7'b0110011: begin
        dec_cls = C_ALU_R;
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_LT;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            3'b111:  dec_op = OP_AND;
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_op    = OP_SUB;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_op    = OP_SRA;
          end
        end
      end
      7'b0010011: begin
        dec_cls   = C_ALU_I;
        dec_legal = 1'b1;
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_LT;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            dec_op    = OP_SLL;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      dec_op = OP_SRL;
            else if (funct7 == 7'b0100000) dec_op = OP_SRA;
            else                           dec_legal = 1'b0;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec_cls   = C_LW;
        dec_legal = (funct3 == 3'b010);
      end
      7'b0100011: begin
        dec_cls   = C_SW;
        dec_legal = (funct3 == 3'b010);
      end
      7'b1100011: begin
        dec_cls   = C_BEQ;
        dec_legal = (funct3 == 3'b000);
        dec_op    = OP_SUB;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) dec_op = OP_ADD;
  end

  // Next-state and Moore outputs; pc_src follows zero only in EX of beq
  always_comb begin
    next_state = S_IF;
    alu_op     = OP_ADD;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    load_pc    = 1'b0;
    illegal    = 1'b0;
    if (cur_state != S_IF && dec_legal) begin
      alu_op  = dec_op;
      alu_src = (dec_cls == C_ALU_I) || (dec_cls == C_LW) || (dec_cls == C_SW);
    end
    case (cur_state)
      S_IF: next_state = S_ID;
      S_ID: begin
        if (dec_legal) begin
          next_state = S_EX;
        end else begin
          illegal    = 1'b1;
          load_pc    = 1'b1;
          next_state = S_IF;
        end
      end
      S_EX: begin
        case (dec_cls)
          C_LW, C_SW: next_state = S_MEM;
          C_BEQ: begin
            load_pc    = 1'b1;
            pc_src     = zero;
            next_state = S_IF;
          end
          default: next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (dec_cls == C_LW) begin
          mem_read   = 1'b1;
          next_state = S_WB;
        end else begin
          mem_write  = (dec_cls == C_SW);
          load_pc    = 1'b1;
          next_state = S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (dec_cls == C_LW);
        load_pc    = 1'b1;
        next_state = S_IF;
      end
      default: next_state = S_IF;
    endcase
    // Reset cycle: nothing may strobe, whatever state we are leaving
    if (rst) begin
      alu_op     = OP_ADD;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      load_pc    = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
